// File: rtl/tx_frame_sequencer.sv
// Sequences one frame of N_BYTES bytes from the tx_buffer into a valid/ready UART.
// Optional sync header before the payload is enabled with the TX_HEADER_EN macro.
module tx_frame_sequencer #(
    parameter int N_BYTES = 9
`ifdef TX_HEADER_EN
    ,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_buf_data,
    output logic       o_buf_rst,
    output logic       o_buf_next,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = $clog2(N_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
`ifdef TX_HEADER_EN
        S_HDR,
`endif
        S_PRESENT,
        S_ADVANCE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d = '0;
`ifdef TX_HEADER_EN
                state_d = S_HDR;
`else
                state_d = S_PRESENT;
`endif
            end
`ifdef TX_HEADER_EN
            S_HDR: begin
                if (i_tx_ready) state_d = S_PRESENT;
            end
`endif
            S_PRESENT: begin
                if (i_tx_ready) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == LAST_IDX) ? S_DONE : S_ADVANCE;
                end
            end
            S_ADVANCE: state_d = S_SETTLE;
            S_SETTLE:  state_d = S_PRESENT;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Abort wins over an accept in the same cycle; that byte is dropped here.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs decode registered state only, so ready never loops back into valid.
    always_comb begin
        o_buf_rst  = 1'b0;
        o_buf_next = 1'b0;
        o_tx_data  = 8'h00;
        o_tx_valid = 1'b0;
        o_busy     = (state_q != S_IDLE);
        o_done     = 1'b0;
        case (state_q)
            S_CLEAR:   o_buf_rst = 1'b1;
`ifdef TX_HEADER_EN
            S_HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = HEADER_BYTE;
            end
`endif
            S_PRESENT: begin
                o_tx_valid = 1'b1;
                o_tx_data  = i_buf_data;
            end
            S_ADVANCE: o_buf_next = 1'b1;
            S_DONE:    o_done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: stimulus pushes expected bytes, done and rewind cycles;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_tx_frame_sequencer;

`ifdef TX_HEADER_EN
    localparam int N = 2;
    localparam int H = 1;
`else
    localparam int N = 9;
    localparam int H = 0;
`endif
    localparam int SB    = (N >= 5) ? 4 : 1;   // byte used for stall/abort tests
    localparam int FRAME = 3 * N + H;
    localparam int C0    = 3 * SB - 1 + H;     // cycle in which byte SB is presented

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_buf_data;
    logic       o_buf_rst;
    logic       o_buf_next;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready = 1'b1;
    logic       o_busy;
    logic       o_done;

    tx_frame_sequencer #(.N_BYTES(N)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_buf_data (i_buf_data),
        .o_buf_rst  (o_buf_rst),
        .o_buf_next (o_buf_next),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Buffer model: byte at address a is a+1.
    logic [7:0] addr = 8'd0;
    always @(posedge i_clk) begin
        if (o_buf_rst)       addr <= 8'd0;
        else if (o_buf_next) addr <= addr + 8'd1;
    end
    assign i_buf_data = addr + 8'd1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int done_q[$];
    int rst_q[$];
    int next_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_empty(input string name, input int sz);
        checks++;
        if (sz != 0) begin
            errors++;
            $display("FAIL %s actual=%0d leftover expected=0", name, sz);
        end
    endtask

    // Monitor
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_tx_valid && i_tx_ready && !i_abort) begin
                $display("tx byte %02h at cyc %0d", o_tx_data, cyc);
                if (exp_q.size() == 0) chk("unexpected_byte", int'(o_tx_data), -1);
                else chk("tx_byte", int'(o_tx_data), int'(exp_q.pop_front()));
            end
            if (o_done) begin
                done_cnt++;
                if (done_q.size() == 0) chk("unexpected_done", cyc, -1);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            if (o_buf_rst) begin
                if (rst_q.size() == 0) chk("unexpected_buf_rst", cyc, -1);
                else chk("buf_rst_cycle", cyc, rst_q.pop_front());
            end
            if (o_buf_next) next_cnt++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_bytes(input int n);
        if (H != 0) exp_q.push_back(8'hA5);
        for (int i = 1; i <= n; i++) exp_q.push_back(8'(i));
    endtask

    // Issue start; returns in cycle 1 of the frame. p0 is cyc value during cycle 1.
    task automatic start_frame(output int p0);
        i_start = 1'b1;
        p0 = cyc + 1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_full_frame(input string tag);
        int p0;
        int nx0;
        nx0 = next_cnt;
        start_frame(p0);
        rst_q.push_back(p0);
        push_bytes(N);
        done_q.push_back(p0 + FRAME - 1);
        for (int k = 1; k <= FRAME; k++) begin
            chk({tag, "_busy"}, int'(o_busy), 1);
            tick();
        end
        chk({tag, "_busy_after"}, int'(o_busy), 0);
        chk({tag, "_buf_next_count"}, next_cnt - nx0, N - 1);
    endtask

    initial begin
        int p0;
        int p1;
        int nx0;
        int dc0;

        // Reset state
        tick();
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_tx_valid), 0);
        chk("rst_buf_rst", int'(o_buf_rst), 0);
        i_rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(o_busy), 0);

        // Full frame, ready high
        run_full_frame("full");

        // Backpressure on byte SB
        nx0 = next_cnt;
        start_frame(p0);
        rst_q.push_back(p0);
        push_bytes(N);
        done_q.push_back(p0 + FRAME + 5 - 1);
        for (int k = 1; k < C0; k++) tick();
        i_tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", int'(o_tx_valid), 1);
            chk("stall_data", int'(o_tx_data), SB);
            chk("stall_no_next", int'(o_buf_next), 0);
            tick();
        end
        i_tx_ready = 1'b1;
        for (int k = C0 + 5; k <= FRAME + 5; k++) tick();
        chk("stall_busy_after", int'(o_busy), 0);
        chk("stall_buf_next_count", next_cnt - nx0, N - 1);

        // Abort in SETTLE after byte SB, then a fresh frame
        nx0 = next_cnt;
        dc0 = done_cnt;
        start_frame(p0);
        rst_q.push_back(p0);
        push_bytes(SB);
        for (int k = 1; k < C0 + 2; k++) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", int'(o_busy), 0);
        tick();
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_buf_next_count", next_cnt - nx0, SB);
        run_full_frame("after_abort");

        // Start pulse mid-frame ignored; start held through DONE chains a second frame
        dc0 = done_cnt;
        start_frame(p0);
        p1 = p0 + FRAME + 1;
        rst_q.push_back(p0);
        rst_q.push_back(p1);
        push_bytes(N);
        push_bytes(N);
        done_q.push_back(p0 + FRAME - 1);
        done_q.push_back(p1 + FRAME - 1);
        for (int k = 1; k < 4; k++) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 5; k < FRAME - 2; k++) tick();
        i_start = 1'b1;
        for (int k = FRAME - 2; k <= FRAME + 1; k++) tick();
        i_start = 1'b0;
        chk("chain_busy", int'(o_busy), 1);
        for (int k = 1; k <= FRAME; k++) tick();
        chk("chain_busy_after", int'(o_busy), 0);
        chk("chain_done_count", done_cnt - dc0, 2);

        // Asynchronous reset mid-frame
        start_frame(p0);
        rst_q.push_back(p0);
        tick();
        chk("pre_reset_valid", int'(o_tx_valid), 1);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(o_tx_valid), 0);
        chk("async_rst_data", int'(o_tx_data), 0);
        chk("async_rst_busy", int'(o_busy), 0);
        chk("async_rst_next", int'(o_buf_next), 0);
        chk("async_rst_done", int'(o_done), 0);
        chk("async_rst_buf_rst", int'(o_buf_rst), 0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_busy", int'(o_busy), 0);
        tick();
        chk("post_rst_idle", int'(o_busy), 0);

        chk_empty("bytes_pending", exp_q.size());
        chk_empty("done_pending", done_q.size());
        chk_empty("buf_rst_pending", rst_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
